// File: rtl/intc_pkg.sv
// rtl/intc_pkg.sv - shared types and constants for the interrupt request controller
package intc_pkg;
  localparam int VEC_W   = 8;
  localparam int MAX_SRC = 32;

  typedef enum logic [0:0] {
    INTC_IDLE,
    INTC_PRESENT
  } intc_state_e;
endpackage

// File: rtl/intc_prio_enc.sv
// rtl/intc_prio_enc.sv - combinational lowest-index-wins priority encoder
module intc_prio_enc #(
  parameter int NUM_SRC = 8,
  parameter int IDX_W   = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic [NUM_SRC-1:0] req,
  output logic               any_valid,
  output logic [IDX_W-1:0]   idx
);
  always_comb begin
    any_valid = 1'b0;
    idx       = '0;
    // Walk downward so the lowest set index is the last one written.
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (req[i]) begin
        any_valid = 1'b1;
        idx       = IDX_W'(i);
      end
    end
  end
endmodule

// File: rtl/int_request_ctrl.sv
// rtl/int_request_ctrl.sv - edge-latched interrupt request controller; INTC_SYNC_EN adds 2-flop input synchronizers
module int_request_ctrl
  import intc_pkg::*;
#(
  parameter int               NUM_SRC  = 8,
  parameter logic [VEC_W-1:0] VEC_BASE = 8'h10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] irq_src,
  input  logic [NUM_SRC-1:0] irq_mask,
  input  logic [NUM_SRC-1:0] pend_clr,
  input  logic               intering,
  output logic               int_sign_external,
  output logic [VEC_W-1:0]   int_num_external,
  output logic [NUM_SRC-1:0] int_pending
);
  localparam int IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  intc_state_e          state, state_nxt;
  logic [NUM_SRC-1:0]   src_in, src_d, src_edge;
  logic [NUM_SRC-1:0]   pending, pending_nxt;
  logic [NUM_SRC-1:0]   sel_oh, ack_oh;
  logic [IDX_W-1:0]     sel, win_idx;
  logic                 any_valid;

`ifdef INTC_SYNC_EN
  logic [NUM_SRC-1:0] sync_q1, sync_q2;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q1 <= '0;
      sync_q2 <= '0;
    end else begin
      sync_q1 <= irq_src;
      sync_q2 <= sync_q1;
    end
  end

  assign src_in = sync_q2;
`else
  assign src_in = irq_src;
`endif

  assign src_edge = src_in & ~src_d;

  // The presented source is shielded from pend_clr; only the core ack retires it.
  assign sel_oh = (state == INTC_PRESENT) ? (NUM_SRC'(1) << sel) : '0;
  assign ack_oh = sel_oh & {NUM_SRC{intering}};

  assign pending_nxt = src_edge | (pending & ~(pend_clr & ~sel_oh) & ~ack_oh);

  intc_prio_enc #(
    .NUM_SRC (NUM_SRC),
    .IDX_W   (IDX_W)
  ) u_prio_enc (
    .req       (pending & irq_mask),
    .any_valid (any_valid),
    .idx       (win_idx)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      INTC_IDLE:    if (any_valid) state_nxt = INTC_PRESENT;
      INTC_PRESENT: if (intering)  state_nxt = INTC_IDLE;
      default:      state_nxt = INTC_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= INTC_IDLE;
      src_d             <= '0;
      pending           <= '0;
      sel               <= '0;
      int_sign_external <= 1'b0;
      int_num_external  <= '0;
    end else begin
      state   <= state_nxt;
      src_d   <= src_in;
      pending <= pending_nxt;
      if (state == INTC_IDLE && any_valid) begin
        sel               <= win_idx;
        int_sign_external <= 1'b1;
        int_num_external  <= VEC_BASE + VEC_W'(win_idx);
      end else if (state == INTC_PRESENT && intering) begin
        int_sign_external <= 1'b0;
      end
    end
  end

  assign int_pending = pending;
endmodule

// File: tb/tb_int_request_ctrl.sv
// tb/tb_int_request_ctrl.sv - directed self-checking bench with a vector scoreboard
module tb_int_request_ctrl;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] irq_src  = 8'h00;
  logic [7:0] irq_mask = 8'hFF;
  logic [7:0] pend_clr = 8'h00;
  logic       intering = 1'b0;
  logic       int_sign_external;
  logic [7:0] int_num_external;
  logic [7:0] int_pending;

  int total = 0;
  int bad   = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  int_request_ctrl #(
    .NUM_SRC  (8),
    .VEC_BASE (8'h10)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .irq_src           (irq_src),
    .irq_mask          (irq_mask),
    .pend_clr          (pend_clr),
    .intering          (intering),
    .int_sign_external (int_sign_external),
    .int_num_external  (int_num_external),
    .int_pending       (int_pending)
  );

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_vec(input string tag);
    logic [7:0] exp;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $error("FAIL %s observed=%h expected=<empty scoreboard>", tag, int_num_external);
    end else begin
      exp = exp_q.pop_front();
      assert (int_sign_external === 1'b1 && int_num_external === exp) else begin
        bad++;
        $error("FAIL %s observed=sign%b/%h expected=sign1/%h", tag,
               int_sign_external, int_num_external, exp);
      end
    end
  endtask

  task automatic ack();
    intering = 1'b1;
    step();
    intering = 1'b0;
  endtask

  initial begin
    step();
    step();
    rst = 1'b0;
    chk("rst_sign", {7'b0, int_sign_external}, 8'h00);
    chk("rst_num", int_num_external, 8'h00);
    chk("rst_pend", int_pending, 8'h00);

    // Single source 3
    irq_src = 8'h08; exp_q.push_back(8'h13);
    step();
    irq_src = 8'h00;
    chk("single_pend", int_pending, 8'h08);
    chk("single_nosign", {7'b0, int_sign_external}, 8'h00);
    step();
    chk_vec("single_vec");
    step(); step();
    chk("single_hold", int_num_external, 8'h13);
    ack();
    chk("single_ack_sign", {7'b0, int_sign_external}, 8'h00);
    chk("single_ack_pend", int_pending, 8'h00);
    intering = 1'b1;
    step();
    intering = 1'b0;
    chk("idle_ack_ignored", {7'b0, int_sign_external}, 8'h00);

    // Priority: sources 5 and 2 together
    irq_src = 8'h24; exp_q.push_back(8'h12); exp_q.push_back(8'h15);
    step();
    irq_src = 8'h00;
    step();
    chk_vec("prio_first");
    ack();
    chk("prio_gap", {7'b0, int_sign_external}, 8'h00);
    chk("prio_pend", int_pending, 8'h20);
    step();
    chk_vec("prio_second");
    ack();
    chk("prio_done", int_pending, 8'h00);

    // Freeze: src 0 arrives while presenting src 4; pend_clr on src 4 ignored
    irq_src = 8'h10; exp_q.push_back(8'h14);
    step();
    irq_src = 8'h00;
    step();
    chk_vec("freeze_first");
    irq_src = 8'h01; exp_q.push_back(8'h10);
    step();
    irq_src = 8'h00;
    chk("freeze_num", int_num_external, 8'h14);
    chk("freeze_pend", int_pending, 8'h11);
    pend_clr = 8'h10;
    irq_mask = 8'h00;
    step();
    pend_clr = 8'h00;
    irq_mask = 8'hFF;
    chk("freeze_clr_ignored", int_pending, 8'h11);
    chk("freeze_num2", int_num_external, 8'h14);
    chk("freeze_sign2", {7'b0, int_sign_external}, 8'h01);
    ack();
    chk("freeze_gap", {7'b0, int_sign_external}, 8'h00);
    step();
    chk_vec("freeze_second");
    ack();

    // Mask: pending latches regardless of mask
    irq_mask = 8'h00;
    irq_src = 8'h02;
    step();
    irq_src = 8'h00;
    step();
    chk("mask_pend", int_pending, 8'h02);
    chk("mask_nosign", {7'b0, int_sign_external}, 8'h00);
    irq_mask = 8'h02; exp_q.push_back(8'h11);
    step();
    chk_vec("mask_unmask");
    ack();
    chk("mask_done", int_pending, 8'h00);

    // pend_clr before unmasking
    irq_mask = 8'h00;
    irq_src = 8'h02;
    step();
    irq_src = 8'h00;
    pend_clr = 8'h02;
    step();
    pend_clr = 8'h00;
    chk("clr_pend", int_pending, 8'h00);
    irq_mask = 8'hFF;
    step(); step();
    chk("clr_nosign", {7'b0, int_sign_external}, 8'h00);

    // Edge on the presented source during the ack cycle
    irq_src = 8'h40; exp_q.push_back(8'h16);
    step();
    irq_src = 8'h00;
    step();
    chk_vec("reedge_first");
    irq_src = 8'h40; intering = 1'b1; exp_q.push_back(8'h16);
    step();
    irq_src = 8'h00; intering = 1'b0;
    chk("reedge_gap", {7'b0, int_sign_external}, 8'h00);
    chk("reedge_pend", int_pending, 8'h40);
    step();
    chk_vec("reedge_second");

    // Reset while presenting
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_sign", {7'b0, int_sign_external}, 8'h00);
    chk("midrst_num", int_num_external, 8'h00);
    chk("midrst_pend", int_pending, 8'h00);

    chk("scoreboard_empty", 8'(exp_q.size()), 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/int_request_ctrl.md
Name: int_request_ctrl

Overview:
- Interrupt request controller that sits directly upstream of the CPU interrupt core.
- Latches rising edges on up to NUM_SRC peripheral interrupt lines and applies a per-source enable mask.
- Picks the highest-priority pending source and presents it as one external interrupt request plus an 8-bit vector number.
- Holds that request stable until the core signals it has taken the interrupt.

Parameters:
- NUM_SRC, 8: number of interrupt source lines; legal range 1..32.
- VEC_BASE, 8'h10: vector number of source 0; source i maps to VEC_BASE+i.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- irq_src  in  NUM_SRC  raw peripheral interrupt lines; active-high, rising-edge significant.
- irq_mask  in  NUM_SRC  1 = source enabled for presentation; driven from a config register.
- pend_clr  in  NUM_SRC  software clear of pending bits; single-cycle pulses.
- intering  in  1  core accept pulse, high for 1 cycle per accepted interrupt.
- int_sign_external  out  1  interrupt request to the core; registered.
- int_num_external  out  8  vector number; registered, valid while int_sign_external=1.
- int_pending  out  NUM_SRC  pending-bit status for software readback.

Behaviour:
- Reset (rst=1 at a clk edge) gives:
  - pending=0, src_d=0, state=IDLE;
  - int_sign_external=0, int_num_external=0, int_pending=0.
  - Reset mid-PRESENT drops the request immediately. Any in-flight core sequence then completes with the vector it already sampled.
- Edge detect:
  - edge[i] = irq_src[i] & ~src_d[i], evaluated each cycle; src_d is registered irq_src.
  - A set edge[i] sets pending[i] at that clk edge.
  - Repeated edges while pending[i]=1 coalesce into one service.
- Pending clear priority, per bit:
  - A new edge wins over pend_clr and over ack.
  - pend_clr[i] clears pending[i], except for the currently presented source while in PRESENT, which is ignored.
- Priority: lowest index wins among (pending & irq_mask).
- FSM, 2 states:
  - IDLE: if (pending & irq_mask)!=0 at a clk edge:
    - go to PRESENT;
    - latch sel = winning index;
    - drive int_sign_external=1 and int_num_external=VEC_BASE+sel (8-bit wrap) from the next cycle.
    - Latency: edge in cycle k, pending after edge k, request visible after edge k+1.
  - PRESENT: sel and int_num_external are frozen.
    - Higher-priority arrivals, mask changes and pend_clr do not alter or withdraw the request, because the core may already have sampled it.
    - On intering=1: clear pending[sel] (unless a new edge on sel arrives that cycle), drop int_sign_external, return to IDLE.
    - Next-candidate evaluation starts the following cycle. The minimum gap between requests is 1 cycle of int_sign_external=0.
- intering while IDLE is ignored.
- int_pending is the registered pending vector, independent of the mask.
- irq_src bits at or above NUM_SRC do not exist; vector numbers beyond 8'hFF wrap modulo 256.

Optional Feature:
- Macro: INTC_SYNC_EN.
- Defined: each irq_src bit passes a 2-flop synchronizer (reset to 0) before edge detect. Edge-to-request latency becomes 4 cycles.
- Undefined: irq_src is used directly and is assumed synchronous to clk. Latency is 2 cycles.

Decomposition:
- Shared package intc_pkg holds:
  - VEC_W=8;
  - state enum {INTC_IDLE, INTC_PRESENT};
  - MAX_SRC=32.
- One sub-module, intc_prio_enc: combinational lowest-index priority encoder. It takes a NUM_SRC request vector and outputs any_valid plus an index.

Test Plan:
- Single source: NUM_SRC=8, mask=8'hFF, pulse irq_src[3] in cycle 5.
  - Required: int_pending[3]=1 after edge 5.
  - Required: int_sign_external=1 with int_num_external=8'h13 after edge 6.
  - Required: intering pulse at cycle 10 gives sign=0 and pending[3]=0 after edge 10.
- Priority: edges on src 5 and src 2 in the same cycle.
  - Required: vector 8'h12 is presented first.
  - Required: after ack and 1 idle cycle, vector 8'h15 is presented.
- Freeze: while presenting src 4 (8'h14), an edge on src 0 arrives.
  - Required: int_num_external stays 8'h14 until ack, then 8'h10 is presented.
- Mask: mask=8'h00, edge on src 1.
  - Required: int_pending=8'h02 and no request.
  - Set mask[1]=1: request 8'h11 appears 1 cycle later.
  - Separately, pend_clr[1] before unmasking clears the bit and no request appears.
- Edge on the presented source during the ack cycle.
  - Required: pending stays set and the same vector is re-presented after 1 idle cycle.
  - rst asserted mid-PRESENT: all outputs are 0 the next cycle.
